// File: rtl/rv32im_muldiv_seq.sv
// Multi-cycle RV32M sequencer: one shared 32-step shift-add / restoring-divide engine
// behind request and result valid/ready handshakes.
module rv32im_muldiv_seq #(
    parameter int XLEN = 32,
    parameter int ITER = 32
) (
    input  logic            clk_i,
    input  logic            rst_ni,
    input  logic            md_valid_i,
    output logic            md_ready_o,
    input  logic [4:0]      md_opcode_i,
    input  logic [XLEN-1:0] md_operand_1_i,
    input  logic [XLEN-1:0] md_operand_2_i,
    input  logic            md_kill_i,
    output logic            md_valid_o,
    input  logic            md_ready_i,
    output logic [XLEN-1:0] md_result_o,
    output logic            md_busy_o
);
    localparam logic [4:0] ALU_OPCODE_MUL    = 5'h10;
    localparam logic [4:0] ALU_OPCODE_MULH   = 5'h11;
    localparam logic [4:0] ALU_OPCODE_MULHSU = 5'h12;
    localparam logic [4:0] ALU_OPCODE_MULHU  = 5'h13;
    localparam logic [4:0] ALU_OPCODE_DIV    = 5'h14;
    localparam logic [4:0] ALU_OPCODE_DIVU   = 5'h15;
    localparam logic [4:0] ALU_OPCODE_REM    = 5'h16;
    localparam logic [4:0] ALU_OPCODE_REMU   = 5'h17;
    localparam int CNT_W = $clog2(ITER);

    typedef enum logic [1:0] {IDLE, CALC, FIX, DONE} state_e;

    state_e              state_q;
    logic [4:0]          op_q;
    logic                neg_q, rem_neg_q, sc_q;
    logic [CNT_W-1:0]    cnt_q;
    logic [XLEN-1:0]     mag_q, result_q;
    logic [2*XLEN-1:0]   acc_q;

    // request decode
    logic            is_mul, is_div, sgn1, sgn2, div0, ovf, sc;
    logic [XLEN-1:0] mag1, mag2, sc_res;

    always_comb begin
        is_mul = (md_opcode_i[4:2] == 3'b100);
        is_div = (md_opcode_i[4:2] == 3'b101);
        sgn1   = md_operand_1_i[XLEN-1] &
                 (md_opcode_i == ALU_OPCODE_MULH || md_opcode_i == ALU_OPCODE_MULHSU ||
                  md_opcode_i == ALU_OPCODE_DIV  || md_opcode_i == ALU_OPCODE_REM);
        sgn2   = md_operand_2_i[XLEN-1] &
                 (md_opcode_i == ALU_OPCODE_MULH || md_opcode_i == ALU_OPCODE_DIV ||
                  md_opcode_i == ALU_OPCODE_REM);
        mag1   = sgn1 ? -md_operand_1_i : md_operand_1_i;
        mag2   = sgn2 ? -md_operand_2_i : md_operand_2_i;
        div0   = is_div && (md_operand_2_i == '0);
        ovf    = (md_opcode_i == ALU_OPCODE_DIV || md_opcode_i == ALU_OPCODE_REM) &&
                 (md_operand_1_i == {1'b1, {(XLEN-1){1'b0}}}) && (md_operand_2_i == '1);
        sc     = div0 || ovf || !(is_mul || is_div);
        sc_res = '0;
        if (div0)
            sc_res = (md_opcode_i == ALU_OPCODE_DIV || md_opcode_i == ALU_OPCODE_DIVU) ?
                     '1 : md_operand_1_i;
        else if (ovf)
            sc_res = (md_opcode_i == ALU_OPCODE_DIV) ? {1'b1, {(XLEN-1){1'b0}}} : '0;
    end

    // one engine step: acc holds {hi, multiplier} for mul, {remainder, quotient} for div
    logic [XLEN:0]     mul_sum, rs, diff;
    logic [2*XLEN-1:0] step_d, prod;
    logic [XLEN-1:0]   quo, rem, fix_res;

    always_comb begin
        mul_sum = {1'b0, acc_q[2*XLEN-1:XLEN]} + (acc_q[0] ? {1'b0, mag_q} : '0);
        rs      = acc_q[2*XLEN-1:XLEN-1];
        diff    = rs - {1'b0, mag_q};
        if (op_q[4:2] == 3'b100)
            step_d = {mul_sum, acc_q[XLEN-1:1]};
        else if (rs[XLEN] || !diff[XLEN])
            step_d = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            step_d = {rs[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};

        prod = neg_q ? -acc_q : acc_q;
        quo  = acc_q[XLEN-1:0];
        rem  = acc_q[2*XLEN-1:XLEN];
        case (op_q)
            ALU_OPCODE_MUL:                                        fix_res = prod[XLEN-1:0];
            ALU_OPCODE_MULH, ALU_OPCODE_MULHSU, ALU_OPCODE_MULHU:  fix_res = prod[2*XLEN-1:XLEN];
            ALU_OPCODE_DIV, ALU_OPCODE_DIVU:                       fix_res = neg_q ? -quo : quo;
            default:                                               fix_res = rem_neg_q ? -rem : rem;
        endcase
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q   <= IDLE;
            op_q      <= '0;
            neg_q     <= 1'b0;
            rem_neg_q <= 1'b0;
            sc_q      <= 1'b0;
            cnt_q     <= '0;
            mag_q     <= '0;
            acc_q     <= '0;
            result_q  <= '0;
        end else if (md_kill_i) begin
            state_q <= IDLE;
        end else begin
            case (state_q)
                IDLE: if (md_valid_i) begin
                    op_q      <= md_opcode_i;
                    neg_q     <= sgn1 ^ sgn2;
                    rem_neg_q <= sgn1;
                    cnt_q     <= '0;
                    mag_q     <= is_mul ? mag1 : mag2;
                    acc_q     <= {{XLEN{1'b0}}, is_mul ? mag2 : mag1};
                    sc_q      <= sc;
                    // short-circuit results skip CALC and take the single FIX edge
                    if (sc) begin
                        result_q <= sc_res;
                        state_q  <= FIX;
                    end else begin
                        state_q  <= CALC;
                    end
                end
                CALC: begin
                    acc_q <= step_d;
                    cnt_q <= cnt_q + 1'b1;
                    if (cnt_q == CNT_W'(ITER-1)) state_q <= FIX;
                end
                FIX: begin
                    if (!sc_q) result_q <= fix_res;
                    state_q <= DONE;
                end
                DONE: if (md_ready_i) state_q <= IDLE;
                default: state_q <= IDLE;
            endcase
        end
    end

    assign md_ready_o  = (state_q == IDLE);
    assign md_busy_o   = (state_q != IDLE);
    assign md_valid_o  = (state_q == DONE);
    assign md_result_o = result_q;
endmodule

// File: tb/tb_rv32im_muldiv_seq.sv
// Directed bench for rv32im_muldiv_seq: hand-computed results, latency, backpressure, kill, reset.
module tb_rv32im_muldiv_seq;
    localparam logic [4:0] OP_MUL = 5'h10, OP_MULH = 5'h11, OP_MULHSU = 5'h12, OP_MULHU = 5'h13;
    localparam logic [4:0] OP_DIV = 5'h14, OP_DIVU = 5'h15, OP_REM = 5'h16, OP_REMU = 5'h17;

    logic        clk_i = 1'b0, rst_ni = 1'b0;
    logic        md_valid_i = 1'b0, md_kill_i = 1'b0, md_ready_i = 1'b0;
    logic [4:0]  md_opcode_i = '0;
    logic [31:0] md_operand_1_i = '0, md_operand_2_i = '0;
    logic        md_ready_o, md_valid_o, md_busy_o;
    logic [31:0] md_result_o;

    int n_chk = 0, n_pass = 0;

    rv32im_muldiv_seq #(.XLEN(32), .ITER(32)) dut (
        .clk_i(clk_i), .rst_ni(rst_ni),
        .md_valid_i(md_valid_i), .md_ready_o(md_ready_o), .md_opcode_i(md_opcode_i),
        .md_operand_1_i(md_operand_1_i), .md_operand_2_i(md_operand_2_i),
        .md_kill_i(md_kill_i), .md_valid_o(md_valid_o), .md_ready_i(md_ready_i),
        .md_result_o(md_result_o), .md_busy_o(md_busy_o)
    );

    always #5 clk_i = ~clk_i;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_chk++;
        if (obs === exp) n_pass++;
        else $display("FAIL %s: got 0x%08h, expected 0x%08h", tag, obs, exp);
    endtask

    // Issue one op, check latency and result, hold md_ready_i low for `hold` cycles, then handshake.
    task automatic run_op(input string tag, input logic [4:0] op, input logic [31:0] a,
                          input logic [31:0] b, input logic [31:0] exp, input int lat, input int hold);
        int cyc;
        @(negedge clk_i);
        chk({tag, "_rdy"}, {31'b0, md_ready_o}, 32'd1);
        md_valid_i = 1'b1; md_opcode_i = op; md_operand_1_i = a; md_operand_2_i = b;
        @(posedge clk_i);
        #1;
        md_valid_i = 1'b0; md_operand_1_i = 32'hDEAD_BEEF; md_operand_2_i = 32'h1234_5678;
        md_opcode_i = OP_DIVU;
        cyc = 0;
        while (!md_valid_o && cyc < 100) begin
            @(posedge clk_i); #1; cyc++;
        end
        chk({tag, "_lat"}, cyc, lat);
        chk({tag, "_res"}, md_result_o, exp);
        for (int i = 0; i < hold; i++) begin
            @(posedge clk_i); #1;
            chk({tag, "_hold_res"}, md_result_o, exp);
            chk({tag, "_hold_rdy"}, {md_valid_o, md_ready_o}, 32'b10);
        end
        @(negedge clk_i);
        md_ready_i = 1'b1;
        @(posedge clk_i); #1;
        md_ready_i = 1'b0;
        chk({tag, "_post_rdy"}, {md_valid_o, md_ready_o}, 32'b01);
    endtask

    initial begin
        int vcnt;
        #2;
        chk("rst_outs", {md_valid_o, md_busy_o, md_ready_o}, 32'b001);
        chk("rst_res", md_result_o, 32'h0);
        #20 rst_ni = 1'b1;

        run_op("mul",    OP_MUL,    32'h20,        32'h5,        32'h0000_00A0, 33, 0);
        run_op("mulh",   OP_MULH,   32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        run_op("mulhsu", OP_MULHSU, 32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'hFFFF_FFFF, 33, 0);
        run_op("mulhu",  OP_MULHU,  32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h7FFF_FFFE, 33, 0);
        run_op("mul_lo", OP_MUL,    32'hFFFF_FFFF, 32'h7FFF_FFFF, 32'h8000_0001, 33, 0);
        run_op("div",    OP_DIV,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFD, 33, 0);
        run_op("rem",    OP_REM,    32'hFFFF_FFF9, 32'h2,         32'hFFFF_FFFF, 33, 0);
        run_op("divu",   OP_DIVU,   32'h20,        32'h5,         32'h6,         33, 0);
        run_op("remu",   OP_REMU,   32'h20,        32'h5,         32'h2,         33, 0);
        run_op("div0",   OP_DIV,    32'h20,        32'h0,         32'hFFFF_FFFF, 1,  0);
        run_op("remu0",  OP_REMU,   32'h20,        32'h0,         32'h20,        1,  0);
        run_op("ovf_d",  OP_DIV,    32'h8000_0000, 32'hFFFF_FFFF, 32'h8000_0000, 1,  0);
        run_op("ovf_r",  OP_REM,    32'h8000_0000, 32'hFFFF_FFFF, 32'h0,         1,  0);
        run_op("nonm",   5'h03,     32'h20,        32'h5,         32'h0,         1,  0);

        run_op("bp",     OP_DIVU,   32'h64,        32'h7,         32'hE,         33, 5);
        run_op("b2b",    OP_DIVU,   32'h20,        32'h5,         32'h6,         33, 0);

        // kill at CALC iteration 10
        @(negedge clk_i);
        md_valid_i = 1'b1; md_opcode_i = OP_MUL; md_operand_1_i = 32'h3; md_operand_2_i = 32'h3;
        @(posedge clk_i); #1 md_valid_i = 1'b0;
        repeat (10) @(posedge clk_i);
        @(negedge clk_i) md_kill_i = 1'b1;
        @(posedge clk_i); #1 md_kill_i = 1'b0;
        chk("kill_state", {md_valid_o, md_busy_o, md_ready_o}, 32'b001);
        vcnt = 0;
        repeat (40) begin @(posedge clk_i); #1; if (md_valid_o) vcnt++; end
        chk("kill_novalid", vcnt, 0);

        // kill coincident with a request
        @(negedge clk_i);
        md_valid_i = 1'b1; md_kill_i = 1'b1; md_opcode_i = OP_MUL;
        md_operand_1_i = 32'h20; md_operand_2_i = 32'h5;
        @(posedge clk_i); #1;
        md_valid_i = 1'b0; md_kill_i = 1'b0;
        chk("kill_req", {md_busy_o, md_ready_o}, 32'b01);

        // reset mid-DIV
        @(negedge clk_i);
        md_valid_i = 1'b1; md_opcode_i = OP_DIV; md_operand_1_i = 32'h100; md_operand_2_i = 32'h3;
        @(posedge clk_i); #1 md_valid_i = 1'b0;
        repeat (5) @(posedge clk_i);
        #3 rst_ni = 1'b0;
        #1;
        chk("rst_mid_outs", {md_valid_o, md_busy_o, md_ready_o}, 32'b001);
        chk("rst_mid_res", md_result_o, 32'h0);
        @(negedge clk_i) rst_ni = 1'b1;
        run_op("mul_after_rst", OP_MUL, 32'h20, 32'h5, 32'h0000_00A0, 33, 0);

        $display("%0d/%0d checks passed", n_pass, n_chk);
        $finish;
    end
endmodule
